ysyx_041514_bim_table: RTL and testbench
========================================

# ysyx_041514_bim_table

Bimodal branch-prediction table: an array of 2^IDX_W two-bit saturating counters indexed by PC.

- Serves one prediction read per cycle toward the fetch stage.
- Accepts one counter update per cycle from the branch-resolve stage.
- Counter arithmetic is delegated to the saturating counter unit.
- After every reset, an init sweep writes every entry before requests are accepted.

## Interface
Parameters:
- IDX_W, 7, index width; table depth 2^IDX_W.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- bim_pred_valid_i  in  1  prediction request.
- bim_pred_pc_i  in  PC_W  PC of the fetched instruction.
- bim_pred_ready_o  out  1  table accepts prediction requests.
- bim_pred_valid_o  out  1  result valid, one-cycle pulse.
- bim_pred_taken_o  out  1  predicted taken (counter MSB).
- bim_pred_cnt_o  out  2  counter value used for the prediction.
- bim_upd_valid_i  in  1  update request.
- bim_upd_pc_i  in  PC_W  PC of the resolved branch.
- bim_upd_taken_i  in  1  1: branch taken (increment); 0: not taken (decrement).
- bim_upd_ready_o  out  1  table accepts updates.
- bim_init_busy_o  out  1  init sweep in progress.

## Operation
- Index = pc[IDX_W+1:2]; higher PC bits are ignored, so aliasing is intended.
- FSM states: INIT, RUN.
  - INIT: entered on reset.
    - An IDX_W-bit sweep counter starts at 0.
    - Each cycle writes 2'b01 (weakly not-taken) to entry[sweep] and increments the sweep counter.
    - The write of entry 2^IDX_W-1 transitions to RUN; the sweep counter wraps to 0.
  - RUN: stays in RUN until the next reset.
- bim_pred_ready_o and bim_upd_ready_o are both equal to !bim_init_busy_o. bim_init_busy_o = (state==INIT).
- Requests presented while ready=0 are dropped. Requesters must hold off; the table keeps no record of them.
- Prediction path:
  - Accepted when valid&ready at a rising edge.
  - The counter is registered at that edge; bim_pred_cnt_o holds it and bim_pred_taken_o = bim_pred_cnt_o[1].
  - With no accepted request, bim_pred_valid_o=0 and the data outputs hold their last values.
  - No output backpressure.
- Update path, two steps:
  - Capture: accepted at edge E0 into a stage register holding valid, index and taken.
  - Write, during the cycle after E0:
    - The stage reads entry[index].
    - The counter unit produces the saturated new value: +1 capped at 3 if taken, -1 floored at 0 if not taken.
    - The new value is written at edge E1.
  - Back-to-back updates to the same index read the already-written value, so there is no lost increment.
- Bypass: when a prediction is accepted at edge E1 and the update stage holds a valid write to the same index, the prediction returns the new counter value, not the stale array value.
- Reset (at any time, including mid-sweep or with an update in flight):
  - FSM to INIT, sweep counter 0, stage valid 0.
  - Pending update is discarded.
  - Array contents need no reset; the sweep overwrites them.

## Timing
- Reset values: bim_pred_valid_o=0, bim_pred_taken_o=0, bim_pred_cnt_o=2'b00, bim_init_busy_o=1, both ready outputs 0.
- Init: 2^IDX_W cycles after rst deasserts; ready rises in the cycle after the last sweep write (128 cycles at default).
- Prediction latency: 1 cycle (request at edge E, result valid in the cycle after E).
- Update latency: 2 edges, from acceptance (E0) to array write (E1).
  - A prediction accepted at E1 or later observes the update, via the bypass at E1.
  - A prediction accepted at E0 observes the old value.
- Throughput: one prediction and one update per cycle, concurrently.
- A prediction and an update in the same cycle to the same index is legal. The prediction sees the old value, because the update has not reached the write stage yet.

## Structure
- Shared package constants:
  - BIM_INIT_VAL=2'b01, BIM_INC=1'b1, BIM_DEC=1'b0.
  - FSM state encoding: INIT=1'b0, RUN=1'b1.
- Sub-module: one instance of ysyx_041514_bim_update in the write stage.
  - req = stage valid.
  - type = stage taken.
  - data_i = entry read at stage index.
- The same new-value output feeds the bypass mux.
- Array: reg [1:0] entries [0:2^IDX_W-1], written from two sources. The INIT sweep write and the RUN stage write are mutually exclusive by state.

## Test plan
- Init: deassert rst, check busy=1 for exactly 128 cycles, then ready=1. Predict PCs 0x80000000 and 0x800001FC -> cnt=01, taken=0.
- Saturate up: four taken updates on 0x80000010, predict 2 cycles after each -> 10, 11, 11, 11.
- Saturate down: three not-taken updates on a fresh entry -> 00, 00, 00; taken=0 throughout.
- Bypass and same-cycle overlap: update taken 0x80000020 at E0, predict 0x80000020 at E1 -> cnt=10. Predict at E0 in the same cycle as the update -> cnt=01.
- Aliasing and back-to-back:
  - Two taken updates on consecutive cycles to 0x80000040 then 0x80000240 (same index) -> cnt=11.
  - Prediction for 0x80000040 -> taken=1.
- Reset mid-operation: assert rst at sweep count 50 and with an update in flight -> outputs return to reset values, the sweep restarts at 0 and takes a full 128 cycles, and the in-flight update does not land.

Source files
------------

// File: rtl/ysyx_041514_bim_table_pkg.sv
// Shared constants and types for the bimodal branch-prediction table.
// Holds the counter init value, the update direction codes and the FSM state type.
package ysyx_041514_bim_table_pkg;

  localparam logic [1:0] BIM_INIT_VAL = 2'b01;
  localparam logic       BIM_INC      = 1'b1;
  localparam logic       BIM_DEC      = 1'b0;

  localparam logic [1:0] BIM_CNT_MAX  = 2'b11;
  localparam logic [1:0] BIM_CNT_MIN  = 2'b00;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bim_state_e;

  // Saturating step of a two-bit counter in the given direction.
  function automatic logic [1:0] bim_sat_step(input logic [1:0] cnt, input logic dir);
    logic [1:0] nxt;
    nxt = cnt;
    if (dir == BIM_INC) begin
      if (cnt != BIM_CNT_MAX) nxt = cnt + 2'd1;
    end else begin
      if (cnt != BIM_CNT_MIN) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ysyx_041514_bim_table_update.sv
// Saturating counter unit used by the table's write stage.
// With no request the counter passes through unchanged.
module ysyx_041514_bim_update
  import ysyx_041514_bim_table_pkg::*;
(
  input  logic       req,
  input  logic       upd_type,
  input  logic [1:0] data_i,
  output logic [1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (req) begin
      data_o = bim_sat_step(data_i, upd_type);
    end
  end

endmodule

// File: rtl/ysyx_041514_bim_table.sv
// Bimodal predictor: 2^IDX_W two-bit counters indexed by pc[IDX_W+1:2].
// One prediction read and one two-stage counter update per cycle, after an init sweep.
module ysyx_041514_bim_table
  import ysyx_041514_bim_table_pkg::*;
#(
  parameter int IDX_W = 7,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bim_pred_valid_i,
  input  logic [PC_W-1:0] bim_pred_pc_i,
  output logic            bim_pred_ready_o,
  output logic            bim_pred_valid_o,
  output logic            bim_pred_taken_o,
  output logic [1:0]      bim_pred_cnt_o,
  input  logic            bim_upd_valid_i,
  input  logic [PC_W-1:0] bim_upd_pc_i,
  input  logic            bim_upd_taken_i,
  output logic            bim_upd_ready_o,
  output logic            bim_init_busy_o
);

  localparam int               DEPTH    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

  bim_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic [1:0]       entries [0:DEPTH-1];

  logic             stg_valid_q;
  logic [IDX_W-1:0] stg_idx_q;
  logic             stg_taken_q;

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             pred_accept;
  logic             upd_accept;
  logic [1:0]       stg_rd_cnt;
  logic [1:0]       stg_new_cnt;
  logic             bypass_hit;
  logic [1:0]       pred_rd_cnt;

  logic             pred_valid_q;
  logic [1:0]       pred_cnt_q;

  // PC bits outside the index field are intentionally ignored (aliasing).
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{bim_pred_pc_i[PC_W-1:IDX_W+2], bim_pred_pc_i[1:0],
                            bim_upd_pc_i[PC_W-1:IDX_W+2], bim_upd_pc_i[1:0]};

  assign pred_idx = bim_pred_pc_i[IDX_W+1:2];
  assign upd_idx  = bim_upd_pc_i[IDX_W+1:2];

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high; ready is low only during the init sweep, and requests offered
  // then are dropped. Prediction results have no backpressure.
  assign bim_init_busy_o  = (state_q == INIT);
  assign bim_pred_ready_o = !bim_init_busy_o;
  assign bim_upd_ready_o  = !bim_init_busy_o;

  assign pred_accept = bim_pred_valid_i && bim_pred_ready_o;
  assign upd_accept  = bim_upd_valid_i && bim_upd_ready_o;

  // Init sweep / run FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + IDX_ONE;
        if (sweep_q == LAST_IDX) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Update capture stage; cleared by reset so an in-flight update never lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid_q <= 1'b0;
      stg_idx_q   <= '0;
      stg_taken_q <= 1'b0;
    end else begin
      stg_valid_q <= upd_accept;
      if (upd_accept) begin
        stg_idx_q   <= upd_idx;
        stg_taken_q <= bim_upd_taken_i;
      end
    end
  end

  assign stg_rd_cnt = entries[stg_idx_q];

  ysyx_041514_bim_update u_update (
    .req      (stg_valid_q),
    .upd_type (stg_taken_q),
    .data_i   (stg_rd_cnt),
    .data_o   (stg_new_cnt)
  );

  // Sweep and stage writes never coincide: the stage is only valid in RUN.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      entries[sweep_q] <= BIM_INIT_VAL;
    end else if (stg_valid_q) begin
      entries[stg_idx_q] <= stg_new_cnt;
    end
  end

  assign bypass_hit  = stg_valid_q && (stg_idx_q == pred_idx);
  assign pred_rd_cnt = bypass_hit ? stg_new_cnt : entries[pred_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_cnt_q   <= 2'b00;
    end else begin
      pred_valid_q <= pred_accept;
      if (pred_accept) pred_cnt_q <= pred_rd_cnt;
    end
  end

  assign bim_pred_valid_o = pred_valid_q;
  assign bim_pred_cnt_o   = pred_cnt_q;
  assign bim_pred_taken_o = pred_cnt_q[1];

endmodule

// File: tb/tb_ysyx_041514_bim_table.sv
// Self-checking bench for ysyx_041514_bim_table: directed plan steps plus a
// randomized phase checked against an array-of-integers counter model.
module tb_ysyx_041514_bim_table;

  localparam int IDX_W = 7;
  localparam int PC_W  = 32;
  localparam int DEPTH = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            bim_pred_valid_i = 1'b0;
  logic [PC_W-1:0] bim_pred_pc_i = '0;
  logic            bim_pred_ready_o;
  logic            bim_pred_valid_o;
  logic            bim_pred_taken_o;
  logic [1:0]      bim_pred_cnt_o;
  logic            bim_upd_valid_i = 1'b0;
  logic [PC_W-1:0] bim_upd_pc_i = '0;
  logic            bim_upd_taken_i = 1'b0;
  logic            bim_upd_ready_o;
  logic            bim_init_busy_o;

  always #5 clk = ~clk;

  ysyx_041514_bim_table #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .bim_pred_valid_i (bim_pred_valid_i),
    .bim_pred_pc_i    (bim_pred_pc_i),
    .bim_pred_ready_o (bim_pred_ready_o),
    .bim_pred_valid_o (bim_pred_valid_o),
    .bim_pred_taken_o (bim_pred_taken_o),
    .bim_pred_cnt_o   (bim_pred_cnt_o),
    .bim_upd_valid_i  (bim_upd_valid_i),
    .bim_upd_pc_i     (bim_upd_pc_i),
    .bim_upd_taken_i  (bim_upd_taken_i),
    .bim_upd_ready_o  (bim_upd_ready_o),
    .bim_init_busy_o  (bim_init_busy_o)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         model [DEPTH];
  int         last_cnt = 0;
  logic [1:0] exp_q [$];

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd128);
  endfunction

  function automatic int sat(input int v, input logic taken);
    if (taken) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string phase);
    chk({phase, "_pred_valid"}, 32'(bim_pred_valid_o), 32'd0);
    chk({phase, "_pred_taken"}, 32'(bim_pred_taken_o), 32'd0);
    chk({phase, "_pred_cnt"},   32'(bim_pred_cnt_o),   32'd0);
    chk({phase, "_busy"},       32'(bim_init_busy_o),  32'd1);
    chk({phase, "_pred_ready"}, 32'(bim_pred_ready_o), 32'd0);
    chk({phase, "_upd_ready"},  32'(bim_upd_ready_o),  32'd0);
  endtask

  // Called right after rst falls (away from an edge); counts busy cycles.
  task automatic wait_init(input string phase);
    int n;
    n = 0;
    while (bim_init_busy_o === 1'b1 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({phase, "_init_cycles"}, 32'(n), 32'd128);
    chk({phase, "_ready_after"}, 32'({bim_pred_ready_o, bim_upd_ready_o}), 32'd3);
    for (int i = 0; i < DEPTH; i++) model[i] = 1;
    last_cnt = 0;
    exp_q.delete();
  endtask

  // One clock of traffic while the table is ready.
  task automatic cycle(input logic pv, input logic [31:0] ppc,
                       input logic uv, input logic [31:0] upc, input logic ut);
    logic [1:0] e;
    bim_pred_valid_i = pv;
    bim_pred_pc_i    = ppc;
    bim_upd_valid_i  = uv;
    bim_upd_pc_i     = upc;
    bim_upd_taken_i  = ut;
    @(posedge clk);
    if (pv) exp_q.push_back(2'(model[idx_of(ppc)]));
    if (uv) model[idx_of(upc)] = sat(model[idx_of(upc)], ut);
    #1;
    bim_pred_valid_i = 1'b0;
    bim_upd_valid_i  = 1'b0;
    chk("pred_valid", 32'(bim_pred_valid_o), 32'(pv));
    if (pv) begin
      e = exp_q.pop_front();
      last_cnt = int'(e);
      chk("pred_cnt", 32'(bim_pred_cnt_o), 32'(e));
      chk("pred_taken", 32'(bim_pred_taken_o), (e >= 2'd2) ? 32'd1 : 32'd0);
    end else begin
      chk("pred_hold", 32'(bim_pred_cnt_o), 32'(last_cnt));
    end
  endtask

  initial begin
    logic        pv, uv, ut;
    logic [31:0] ppc, upc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("por");
    rst = 1'b0;
    wait_init("por");

    // Fresh table: first and last entries read weakly not-taken.
    cycle(1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0);
    chk("init_first", 32'(bim_pred_cnt_o), 32'd1);
    cycle(1'b1, 32'h8000_01FC, 1'b0, 32'h0, 1'b0);
    chk("init_last", 32'(bim_pred_cnt_o), 32'd1);

    // Saturate up.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 32'h8000_0010, 1'b1);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b0);
      chk("sat_up", 32'(bim_pred_cnt_o), (k == 0) ? 32'd2 : 32'd3);
    end

    // Saturate down on an untouched entry.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 32'h8000_0030, 1'b0);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      cycle(1'b1, 32'h8000_0030, 1'b0, 32'h0, 1'b0);
      chk("sat_down", 32'(bim_pred_cnt_o), 32'd0);
      chk("sat_down_taken", 32'(bim_pred_taken_o), 32'd0);
    end

    // Same-cycle overlap sees the old value; next cycle sees the bypassed one.
    cycle(1'b1, 32'h8000_0020, 1'b1, 32'h8000_0020, 1'b1);
    chk("overlap_old", 32'(bim_pred_cnt_o), 32'd1);
    cycle(1'b1, 32'h8000_0020, 1'b0, 32'h0, 1'b0);
    chk("bypass_new", 32'(bim_pred_cnt_o), 32'd2);

    // Aliased back-to-back updates must both count.
    cycle(1'b0, 32'h0, 1'b1, 32'h8000_0040, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 32'h8000_0240, 1'b1);
    cycle(1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b0);
    chk("alias_cnt", 32'(bim_pred_cnt_o), 32'd3);
    chk("alias_taken", 32'(bim_pred_taken_o), 32'd1);

    // Randomized concurrent traffic on a few hot indices.
    for (int k = 0; k < 400; k++) begin
      pv  = 1'($urandom_range(0, 1));
      uv  = 1'($urandom_range(0, 1));
      ut  = 1'($urandom_range(0, 1));
      ppc = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      upc = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      cycle(pv, ppc, uv, upc, ut);
    end

    // Reset with an update in flight and a live prediction output.
    cycle(1'b1, 32'h8000_0050, 1'b1, 32'h8000_0050, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("inflight");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_init("inflight");
    cycle(1'b1, 32'h8000_0050, 1'b0, 32'h0, 1'b0);
    chk("inflight_dropped", 32'(bim_pred_cnt_o), 32'd1);

    // Reset in the middle of the sweep.
    cycle(1'b0, 32'h0, 1'b1, 32'h8000_0060, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_sweep_busy", 32'({bim_init_busy_o, bim_pred_ready_o, bim_upd_ready_o}), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("mid_sweep");
    @(negedge clk);
    rst = 1'b0;
    wait_init("mid_sweep");
    cycle(1'b1, 32'h8000_0060, 1'b0, 32'h0, 1'b0);
    chk("mid_sweep_reinit", 32'(bim_pred_cnt_o), 32'd1);
    cycle(1'b1, 32'h8000_01FC, 1'b0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
